// File: rtl/deskew_ctrl_fsm.sv
// deskew_ctrl_fsm: PCS multi-lane deskew, measures per-lane AM offsets and loads FIFO delays.
// Define DESKEW_FSM_STATS_EN to add o_realign_count (falling edges of o_align_status).
`timescale 1ns/1ps
module deskew_ctrl_fsm #(
  parameter int N_LANES   = 20,
  parameter int MAX_SKEW  = 16,
  parameter int NB_COUNT  = $clog2(MAX_SKEW)+1,
  parameter int N_CONFIRM = 2,
  parameter int N_LOSS    = 3
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic [N_LANES-1:0]           i_am_lock,
  input  logic                         i_resync,
  input  logic [N_LANES-1:0]           i_start_of_lane,
  output logic [N_LANES*NB_COUNT-1:0]  o_lane_delay,
  output logic                         o_set_fifo_delay,
  output logic                         o_align_status,
  output logic                         o_deskew_error,
  output logic [1:0]                   o_state
`ifdef DESKEW_FSM_STATS_EN
  ,output logic [15:0]                 o_realign_count
`endif
);

  localparam int CW = $clog2(N_CONFIRM+1);
  localparam int LW = $clog2(N_LOSS+1);

  typedef enum logic [1:0] {
    INIT       = 2'd0,
    MEASURE    = 2'd1,
    WAIT_CHECK = 2'd2,
    CHECK      = 2'd3
  } state_t;

  typedef logic [N_LANES-1:0][NB_COUNT-1:0] lane_vec_t;

  state_t             state_q, state_d;
  logic [NB_COUNT-1:0] cnt_q, cnt_d, cnt_cur, mx;
  logic [N_LANES-1:0] arr_q, arr_d, arr_cur;
  lane_vec_t          off_q, off_d, off_cur;
  lane_vec_t          ref_q, ref_d;
  lane_vec_t          delay_q, delay_d;
  logic [CW-1:0]      conf_q, conf_d;
  logic [LW-1:0]      loss_q, loss_d, loss_inc;
  logic               align_q, align_d;
  logic               set_fifo, err, load;
  logic               in_rnd, start, is_meas, match;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arr_d    = arr_q;
    off_d    = off_q;
    ref_d    = ref_q;
    delay_d  = delay_q;
    conf_d   = conf_q;
    loss_d   = loss_q;
    align_d  = align_q;
    set_fifo = 1'b0;
    err      = 1'b0;
    load     = 1'b0;
    in_rnd   = (state_q == MEASURE) || (state_q == CHECK);
    start    = ((state_q == INIT) || (state_q == WAIT_CHECK))
               && (|i_start_of_lane);
    is_meas  = (state_q == INIT) || (state_q == MEASURE);
    cnt_cur  = in_rnd ? cnt_q : '0;
    arr_cur  = arr_q | i_start_of_lane;
    loss_inc = loss_q + LW'(1);
    mx       = '0;
    for (int i = 0; i < N_LANES; i++) begin
      off_cur[i] = arr_q[i] ? off_q[i] : cnt_cur;
      if (off_cur[i] > mx) mx = off_cur[i];
    end
    match = (off_cur == ref_q);

    if (i_reset || i_resync || !(&i_am_lock)) begin
      state_d = INIT;
      cnt_d   = '0;
      arr_d   = '0;
      off_d   = '0;
      ref_d   = '0;
      delay_d = '0;
      conf_d  = '0;
      loss_d  = '0;
      align_d = 1'b0;
    end else if (i_enable) begin
      if (in_rnd && cnt_q == NB_COUNT'(MAX_SKEW)) begin
        err     = 1'b1;
        state_d = INIT;
        cnt_d   = '0;
        arr_d   = '0;
        off_d   = '0;
        ref_d   = '0;
        conf_d  = '0;
        loss_d  = '0;
        align_d = 1'b0;
      end else if (in_rnd || start) begin
        if (&arr_cur) begin
          state_d = WAIT_CHECK;
          cnt_d   = '0;
          arr_d   = '0;
          off_d   = '0;
          if (is_meas) begin
            load = 1'b1;
          end else if (match) begin
            loss_d = '0;
            if (conf_q != CW'(N_CONFIRM)) conf_d = conf_q + CW'(1);
            if (conf_d == CW'(N_CONFIRM)) align_d = 1'b1;
          end else begin
            err = 1'b1;
            if (!align_q) begin
              load = 1'b1;
            end else if (loss_inc == LW'(N_LOSS)) begin
              align_d = 1'b0;
              loss_d  = '0;
              load    = 1'b1;
            end else begin
              loss_d = loss_inc;
            end
          end
        end else begin
          state_d = is_meas ? MEASURE : CHECK;
          arr_d   = arr_cur;
          off_d   = off_cur;
          cnt_d   = cnt_cur + NB_COUNT'(1);
        end
      end
    end

    // Latest arrival gets zero delay; earlier lanes wait for it.
    if (load) begin
      set_fifo = 1'b1;
      ref_d    = off_cur;
      conf_d   = '0;
      for (int i = 0; i < N_LANES; i++) delay_d[i] = mx - off_cur[i];
    end
  end

  always_ff @(posedge i_clock) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    arr_q   <= arr_d;
    off_q   <= off_d;
    ref_q   <= ref_d;
    delay_q <= delay_d;
    conf_q  <= conf_d;
    loss_q  <= loss_d;
    align_q <= align_d;
  end

  assign o_lane_delay     = delay_q;
  assign o_set_fifo_delay = set_fifo;
  assign o_deskew_error   = err;
  assign o_align_status   = align_q;
  assign o_state          = state_q;

`ifdef DESKEW_FSM_STATS_EN
  logic [15:0] rc_q, rc_d;

  // Survives i_resync so realignments stay visible across restarts.
  always_comb begin
    rc_d = rc_q;
    if (align_q && !align_d && rc_q != 16'hFFFF) rc_d = rc_q + 16'd1;
    if (i_reset) rc_d = '0;
  end

  always_ff @(posedge i_clock) begin
    rc_q <= rc_d;
  end

  assign o_realign_count = rc_q;
`endif

endmodule
